data_mem_arbiter: RTL and testbench

//  Shares the single data_mem port between two requesters: m0 (CPU load/store) and m1 (DMA/debug loader).

---
 rtl/data_mem_arbiter.sv | 119 +++++++++++
 tb/tb_data_mem_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing the single data_mem port between m0 (CPU) and m1 (DMA/loader).
// state  | meaning: IDLE = sample requests, ACCESS = drive data_mem and grant, RESP = return rdata/err.
module data_mem_arbiter #(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int unsigned DEPTH     = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        mem_output_en,
  output logic        mem_MemWr,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
);

  localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(4 * DEPTH) - 32'd4;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state_q, state_d;
  logic        sel_q, sel_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        ok_q, ok_d;
  logic [31:0] rdata_q, rdata_d;
  logic        last_q, last_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ok_q    <= 1'b0;
      rdata_q <= '0;
      last_q  <= 1'b1;  // pretend m1 went last so m0 wins the first tie
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ok_q    <= ok_d;
      rdata_q <= rdata_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ok_d    = ok_q;
    rdata_d = rdata_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          sel_d   = m1_req & (~m0_req | ~last_q);
          we_d    = sel_d ? m1_we    : m0_we;
          addr_d  = sel_d ? m1_addr  : m0_addr;
          wdata_d = sel_d ? m1_wdata : m0_wdata;
          ok_d    = (addr_d[1:0] == 2'b00) && (addr_d >= BASE_ADDR) && (addr_d <= LAST_ADDR);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        rdata_d = (ok_q && !we_q) ? mem_data_out : '0;
        state_d = RESP;
      end
      RESP: begin
        last_d  = sel_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  logic in_access, in_resp, mem_drive;
  assign in_access = (state_q == ACCESS);
  assign in_resp   = (state_q == RESP);
  assign mem_drive = in_access & ok_q;

  assign m0_gnt    = in_access & ~sel_q;
  assign m1_gnt    = in_access &  sel_q;
  assign m0_rvalid = in_resp & ~sel_q;
  assign m1_rvalid = in_resp &  sel_q;
  assign m0_err    = in_resp & ~sel_q & ~ok_q;
  assign m1_err    = in_resp &  sel_q & ~ok_q;
  assign m0_rdata  = (in_resp & ~sel_q) ? rdata_q : '0;
  assign m1_rdata  = (in_resp &  sel_q) ? rdata_q : '0;

  // A write must never land on the edge that is also resetting the arbiter.
  assign mem_MemWr     = mem_drive & we_q & ~rst;
  assign mem_output_en = mem_drive & ~we_q;
  assign mem_address   = mem_drive ? addr_q  : '0;
  assign mem_data_in   = mem_drive ? wdata_q : '0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: data_mem model, transaction-level reference model with per-cycle
// output comparison, and directed scenarios with literal expectations.
module tb_data_mem_arbiter;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_output_en, mem_MemWr;
  logic [31:0] mem_address, mem_data_in, mem_data_out;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  data_mem_arbiter #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_output_en(mem_output_en), .mem_MemWr(mem_MemWr),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  // data_mem: combinational read when enabled, write at the clock edge
  logic [31:0] mem [DEPTH];
  logic [31:0] mem_idx;
  assign mem_idx      = (mem_address - BASE) >> 2;
  assign mem_data_out = mem_output_en ? mem[mem_idx[9:0]] : 32'h0;
  always @(posedge clk) if (mem_MemWr) mem[mem_idx[9:0]] <= mem_data_in;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Reference model: one transaction at a time, accepted at edge t0, granted in the cycle after,
  // answered the cycle after that, next acceptance no earlier than edge t0+3.
  logic [31:0] ref_mem [DEPTH];
  int          edge_cnt = 0;
  bit          model_valid = 0;
  int          t0 = -10;
  int          last_port = 1;
  int          t_port;
  logic        t_we, t_ok;
  logic [31:0] t_addr, t_wdata, t_rd;

  function automatic logic legal(input logic [31:0] a);
    longint la;
    la = longint'(a);
    return (la % 4 == 0) && (la >= longint'(BASE)) && (la < longint'(BASE) + 4 * DEPTH);
  endfunction

  always @(posedge clk) begin
    edge_cnt++;
    if (rst) begin
      t0 = -10;
      last_port = 1;
      model_valid = 1;
    end else begin
      if (edge_cnt == t0 + 1 && t_we && t_ok) ref_mem[(t_addr - BASE) >> 2] = t_wdata;
      if (edge_cnt >= t0 + 3 && (m0_req || m1_req)) begin
        t_port    = (m0_req && m1_req) ? 1 - last_port : (m1_req ? 1 : 0);
        last_port = t_port;
        t_we      = t_port ? m1_we : m0_we;
        t_addr    = t_port ? m1_addr : m0_addr;
        t_wdata   = t_port ? m1_wdata : m0_wdata;
        t_ok      = legal(t_addr);
        t_rd      = (t_ok && !t_we) ? ref_mem[(t_addr - BASE) >> 2] : 32'h0;
        t0        = edge_cnt;
      end
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      logic acc, rsp;
      logic [34:0] e0, e1;
      logic [65:0] em;
      acc = (edge_cnt == t0);
      rsp = (edge_cnt == t0 + 1);
      e0 = '0; e1 = '0; em = '0;
      if (acc) begin
        if (t_port == 0) e0[34] = 1'b1; else e1[34] = 1'b1;
        if (t_ok) em = {!t_we, t_we && !rst, t_addr, t_wdata};
      end
      if (rsp) begin
        if (t_port == 0) e0[33:0] = {1'b1, !t_ok, t_rd};
        else             e1[33:0] = {1'b1, !t_ok, t_rd};
      end
      check("m0_port", {m0_gnt, m0_rvalid, m0_err, m0_rdata}, e0);
      check("m1_port", {m1_gnt, m1_rvalid, m1_err, m1_rdata}, e1);
      check("mem_port", {mem_output_en, mem_MemWr, mem_address, mem_data_in}, em);
    end
  end

  bit memwr_seen;
  always @(negedge clk) if (mem_MemWr) memwr_seen = 1;

  task automatic do_access(input string name, input int port, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output logic err,
                           output int gnt_lat, output int rv_lat);
    int start;
    bit got;
    @(posedge clk); #1;
    if (port == 0) begin m0_req = 1; m0_we = we; m0_addr = addr; m0_wdata = wdata; end
    else           begin m1_req = 1; m1_we = we; m1_addr = addr; m1_wdata = wdata; end
    start = edge_cnt;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = (port == 0) ? m0_gnt : m1_gnt;
    end
    gnt_lat = edge_cnt - start;
    if (!got) check({name, "_gnt_seen"}, 0, 1);
    @(posedge clk); #1;
    if (port == 0) m0_req = 0; else m1_req = 0;
    got = 0;
    rdata = '0; err = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = (port == 0) ? m0_rvalid : m1_rvalid;
    end
    rv_lat = edge_cnt - start;
    if (!got) check({name, "_rvalid_seen"}, 0, 1);
    rdata = (port == 0) ? m0_rdata : m1_rdata;
    err   = (port == 0) ? m0_err : m1_err;
  endtask

  logic [31:0] rd;
  logic        er;
  int          gl, rl;
  int          g_port[$];
  int          g_off[$];

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = 32'hD000_0000 | (i * 4);
      ref_mem[i] = 32'hD000_0000 | (i * 4);
    end
    rst = 1;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {m0_gnt, m0_rvalid, m0_err, m0_rdata, m1_gnt, m1_rvalid, m1_err, m1_rdata,
                            mem_output_en, mem_MemWr, mem_address, mem_data_in}, 0);
    @(posedge clk); #1 rst = 0;

    // read of word 3
    do_access("read_w3", 0, 0, 32'h1000_000C, 0, rd, er, gl, rl);
    check("read_w3_rdata", rd, 32'hD000_000C);
    check("read_w3_err", er, 0);
    check("read_w3_gnt_lat", gl, 1);
    check("read_w3_rv_lat", rl, 2);

    // write from m1, read back from m0
    do_access("wr_28", 1, 1, 32'h1000_0028, 32'h0000_FF28, rd, er, gl, rl);
    check("wr_28_rdata", rd, 0);
    check("wr_28_mem", mem[10], 32'h0000_FF28);
    do_access("rb_28", 0, 0, 32'h1000_0028, 0, rd, er, gl, rl);
    check("rb_28_rdata", rd, 32'h0000_FF28);
    check("rb_28_err", er, 0);

    // address errors never reach memory
    memwr_seen = 0;
    do_access("misalign", 0, 1, 32'h1000_0026, 32'hDEAD_BEEF, rd, er, gl, rl);
    check("misalign_err", er, 1);
    check("misalign_rdata", rd, 0);
    do_access("range_hi", 1, 0, 32'h1000_1000, 0, rd, er, gl, rl);
    check("range_hi_err", er, 1);
    check("range_hi_rdata", rd, 0);
    check("err_no_memwr", memwr_seen, 0);
    check("err_mem_w9", mem[9], 32'hD000_0024);

    // reset while the write is being presented
    @(posedge clk); #1;
    m0_req = 1; m0_we = 1; m0_addr = 32'h1000_0024; m0_wdata = 32'h0000_FF24;
    @(posedge clk); #1;
    rst = 1; m0_req = 0;
    @(negedge clk);
    check("rst_access_gnt_wr", {m0_gnt, mem_MemWr}, 2'b10);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check("rst_after_outputs", {m0_gnt, m0_rvalid, m0_err, m0_rdata, m1_gnt, m1_rvalid, m1_err, m1_rdata,
                                mem_output_en, mem_MemWr, mem_address, mem_data_in}, 0);
    do_access("rb_24", 0, 0, 32'h1000_0024, 0, rd, er, gl, rl);
    check("rb_24_rdata", rd, 32'hD000_0024);

    // range boundaries
    do_access("top_word", 1, 0, 32'h1000_0FFC, 0, rd, er, gl, rl);
    check("top_word_err", er, 0);
    check("top_word_rdata", rd, 32'hD000_0FFC);
    do_access("below_base", 0, 0, 32'h0FFF_FFFC, 0, rd, er, gl, rl);
    check("below_base_err", er, 1);
    check("below_base_rdata", rd, 0);

    // contention from reset: both held
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    m0_req = 1; m0_we = 0; m0_addr = 32'h1000_0000;
    m1_req = 1; m1_we = 0; m1_addr = 32'h1000_0004;
    begin
      int e0;
      e0 = edge_cnt;
      for (int k = 1; k <= 12; k++) begin
        @(negedge clk);
        if (m0_gnt) begin g_port.push_back(0); g_off.push_back(edge_cnt - e0); end
        if (m1_gnt) begin g_port.push_back(1); g_off.push_back(edge_cnt - e0); end
      end
    end
    @(posedge clk); #1 m0_req = 0; m1_req = 0;
    check("cont_count", g_port.size(), 4);
    if (g_port.size() == 4) begin
      check("cont_order", {g_port[0][1:0], g_port[1][1:0], g_port[2][1:0], g_port[3][1:0]}, 8'b00_01_00_01);
      check("cont_offsets", {g_off[0][7:0], g_off[1][7:0], g_off[2][7:0], g_off[3][7:0]}, 32'h01_04_07_0A);
    end
    repeat (5) @(posedge clk);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
